uart_wb_master: RTL and testbench
=================================

Name: uart_wb_master

Overview:
- Command-driven Wishbone classic master that sits directly upstream of the UART core's Wishbone slave port.
- Accepts register read/write commands from a host/sequencer over a valid/ready channel and buffers them in a small FIFO.
- Issues each command as a single Wishbone cycle and returns one response per command: read data plus an error flag on ack timeout.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
- TIMEOUT, 16, max cycles stb may stay asserted without ack before the cycle is aborted (>=2)

Ports:
- clock  in  1  system clock, all logic on posedge
- wb_rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command FIFO not full
- cmd_we_i  in  1  1=write, 0=read
- cmd_addr_i  in  5  UART register address
- cmd_data_i  in  8  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  8  read data (0 for writes and on error)
- rsp_err_o  out  1  cycle timed out
- wb_addr_o  out  5  to slave wb_addr_i
- wb_sel_o  out  4  to slave wb_sel_i
- wb_dat_o  out  8  to slave data input
- wb_dat_i  in  8  from slave wb_dat_o
- wb_we_o  out  1  to slave wb_we_i
- wb_stb_o  out  1  to slave wb_stb_i
- wb_cyc_o  out  1  to slave wb_cyc_i
- wb_ack_i  in  1  from slave wb_ack_o

Behaviour:
- Reset (async, active-low): all outputs 0 except cmd_ready_o=1; FIFO emptied; FSM=IDLE; timeout counter=0.
- Reset asserted mid-cycle drops wb_cyc_o/wb_stb_o immediately (asynchronously). Pending commands and any undelivered response are discarded.
- FIFO:
  - Push when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = !full. A full FIFO refuses a push even if a pop occurs in the same cycle.
  - Pointers wrap modulo CMD_DEPTH. The count is held in $clog2(CMD_DEPTH)+1 bits.
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - Waits for the FIFO to be non-empty.
  - At that edge: pop the head; register wb_addr_o, wb_dat_o (cmd_data, or 0 for reads), wb_we_o and wb_sel_o; set wb_cyc_o=wb_stb_o=1; clear the counter; go to BUS.
  - A command pushed at edge N into an empty FIFO shows stb high after edge N+1.
- wb_sel_o = 4'b0001 << wb_addr_o[1:0]. It is held constant for the whole cycle.
- BUS:
  - Each edge, wb_ack_i is sampled.
  - On ack:
    - Drop cyc/stb/we at that edge.
    - rsp_data_o = wb_dat_i for reads, 0 for writes.
    - rsp_err_o=0; rsp_valid_o=1; go to RSP.
  - No ack: the counter increments. When the counter == TIMEOUT-1 and no ack, abort:
    - Drop cyc/stb.
    - rsp_data_o=0, rsp_err_o=1, rsp_valid_o=1; go to RSP.
  - Ack at the terminal count wins (normal completion).
- RSP:
  - rsp_* are held stable while rsp_valid_o && !rsp_ready_i.
  - On rsp_ready_i: rsp_valid_o=0 and go to IDLE.
  - The next bus cycle starts no earlier than the edge after the response handshake. Each command gets exactly one response, in order.
- wb_ack_i is ignored outside BUS.
- All wb_* outputs are stable for the entire cycle. cyc and stb always rise and fall together.
- Minimum bus occupancy: 1 cycle with zero-wait ack.

Decomposition:
- Shared package uart_wb_pkg:
  - UART_AW=5, UART_DW=8, UART_SW=4
  - typedef uart_cmd_t {we, addr[4:0], data[7:0]}
  - enum mst_state_t {IDLE, BUS, RSP}
  - UART register address constants (RBR_THR=0, IER=1, IIR_FCR=2, LCR=3, LSR=5).
- One sub-module: uart_cmd_fifo (synchronous FIFO of uart_cmd_t, parameter CMD_DEPTH, full/empty flags). The FSM and counter live in the top.

Test Plan:
- Write LCR: cmd {we=1, addr=3, data=0x83}, slave acks on the 2nd stb cycle -> wb_sel_o=4'b1000, wb_dat_o=0x83, stb high exactly 2 cycles, rsp_valid with err=0, data=0x00.
- Read LSR: cmd {we=0, addr=5}, slave returns 0x60 with ack -> rsp_data_o=0x60, rsp_err_o=0, wb_sel_o=4'b0010.
- Back-to-back: push 5 commands with rsp_ready_i held 1 and CMD_DEPTH=4 -> cmd_ready_o low after 4 buffered while the first is not popped. All 5 complete in order, with exactly 5 responses.
- Timeout: slave never acks, TIMEOUT=16 -> stb high exactly 16 cycles, then drops; rsp_err_o=1, rsp_data_o=0x00. Late ack afterwards is ignored.
- Backpressure plus reset: hold rsp_ready_i=0 for 10 cycles -> rsp_* stable and no new stb. Then assert wb_rst_ni=0 mid-BUS on the next command -> cyc/stb fall immediately, cmd_ready_o=1, rsp_valid_o=0.
- Boundary: ack asserted in the same cycle the counter reaches TIMEOUT-1 -> response has err=0 with valid read data.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// Shared types and constants for the UART Wishbone command master.
//   uart_cmd_t  : one buffered host command {we, addr, data}
//   mst_state_t : bus master FSM states
//   sel_of()    : byte-lane select for a UART register address
package uart_wb_pkg;

  localparam int UART_AW = 5;
  localparam int UART_DW = 8;
  localparam int UART_SW = 4;
  localparam int CMD_W   = 1 + UART_AW + UART_DW;

  // UART register map (word offsets on the slave port)
  localparam logic [UART_AW-1:0] RBR_THR = 5'd0;
  localparam logic [UART_AW-1:0] IER     = 5'd1;
  localparam logic [UART_AW-1:0] IIR_FCR = 5'd2;
  localparam logic [UART_AW-1:0] LCR     = 5'd3;
  localparam logic [UART_AW-1:0] LSR     = 5'd5;

  typedef struct packed {
    logic               we;
    logic [UART_AW-1:0] addr;
    logic [UART_DW-1:0] data;
  } uart_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } mst_state_t;

  // One-hot lane select from the low address bits.
  function automatic logic [UART_SW-1:0] sel_of(input logic [UART_AW-1:0] a);
    return 4'b0001 << a[1:0];
  endfunction

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous command FIFO.
//   clk_i, rst_ni : clock, async active-low reset (empties the FIFO)
//   push_i/data_i : write request; ignored while full (even with a pop)
//   pop_i         : drop the head entry; ignored while empty
//   head_o        : current head entry (valid while !empty_o)
//   full_o/empty_o: occupancy flags
module uart_cmd_fifo
  import uart_wb_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [CMD_W-1:0] data_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(CMD_DEPTH);

  logic [CMD_W-1:0] mem_q [CMD_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(CMD_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full blocks push based on the registered count only, so a same-cycle
  // pop never frees a slot early.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Power-of-two depth: pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_wb_master.sv
// Command-driven Wishbone classic master for the UART register slave.
//   clock, wb_rst_ni      : clock, async active-low reset
//   cmd_*                 : host command channel (valid/ready), buffered
//   rsp_*                 : one response per command, in order
//                           (rsp_err_o=1 means no ack within TIMEOUT cycles)
//   wb_*                  : Wishbone classic master port (cyc == stb)
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic               clock,
  input  logic               wb_rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_we_i,
  input  logic [UART_AW-1:0] cmd_addr_i,
  input  logic [UART_DW-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [UART_DW-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic [UART_AW-1:0] wb_addr_o,
  output logic [UART_SW-1:0] wb_sel_o,
  output logic [UART_DW-1:0] wb_dat_o,
  input  logic [UART_DW-1:0] wb_dat_i,
  output logic               wb_we_o,
  output logic               wb_stb_o,
  output logic               wb_cyc_o,
  input  logic               wb_ack_i
);

  localparam int CW = $clog2(TIMEOUT);

  mst_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [UART_AW-1:0] addr_q, addr_d;
  logic [UART_SW-1:0] sel_q, sel_d;
  logic [UART_DW-1:0] dat_q, dat_d;
  logic               we_q, we_d;
  logic               cyc_q, cyc_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [UART_DW-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  uart_cmd_t cmd_in, head;
  logic      fifo_full, fifo_empty, pop;

  assign cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, data: cmd_data_i};

  uart_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
    .clk_i  (clock),
    .rst_ni (wb_rst_ni),
    .push_i (cmd_valid_i),
    .data_i (cmd_in),
    .pop_i  (pop),
    .head_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_d  = head.addr;
          sel_d   = sel_of(head.addr);
          dat_d   = head.we ? head.data : '0;
          we_d    = head.we;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so an ack on the terminal count completes
        // normally instead of aborting.
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_data_d  = we_q ? '0 : wb_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign wb_addr_o   = addr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  // stb and cyc share one flop so they can never diverge.
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Scoreboard bench for uart_wb_master: a behavioural slave acks after a
// per-command delay; expected bus fields and responses are queued at issue.
module tb_uart_wb_master;
  import uart_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  logic       clock = 1'b0;
  logic       wb_rst_ni;
  logic       cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [4:0] cmd_addr_i;
  logic [7:0] cmd_data_i;
  logic       rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [7:0] rsp_data_o;
  logic [4:0] wb_addr_o;
  logic [3:0] wb_sel_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  uart_wb_master #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clock(clock), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .wb_addr_o(wb_addr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] dat;
    logic [3:0] sel;
    int         len;
    int         dly;
  } bus_exp_t;
  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_exp_t;

  bus_exp_t   exp_bus[$];
  rsp_exp_t   exp_rsp[$];
  logic [7:0] slave_regs [32];
  logic [7:0] ref_regs   [32];

  int n_chk = 0, n_pass = 0;
  int n_rsp = 0, stb_rises = 0, cyc_stb_bad = 0;
  int late_ack = 0;
  int rsp_mode = 0;   // 0: always ready, 1: random, 2: never ready

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Reference model: a command whose ack comes within TIMEOUT stb cycles
  // succeeds; writes then update the register image, reads return it.
  task automatic push_cmd(input logic we, input logic [4:0] addr,
                          input logic [7:0] data, input int dly);
    bus_exp_t b;
    rsp_exp_t r;
    bit ok;
    int guard = 0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_data_i = data;
    forever begin
      @(negedge clock);
      if (cmd_ready_o) break;
      if (++guard > 300) begin
        fail_now("cmd_accept");
        cmd_valid_i = 1'b0;
        return;
      end
    end
    ok    = (dly < TMO);
    b.we  = we; b.addr = addr; b.dat = we ? data : 8'h00;
    b.sel = 4'(1 << (addr % 4));
    b.len = ok ? dly + 1 : TMO;
    b.dly = dly;
    r.err = !ok;
    if (we) begin
      r.data = 8'h00;
      if (ok) ref_regs[addr] = data;
    end else begin
      r.data = ok ? ref_regs[addr] : 8'h00;
    end
    exp_bus.push_back(b);
    exp_rsp.push_back(r);
    @(posedge clock); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    forever begin
      @(negedge clock);
      if (exp_rsp.size() == 0 && !wb_cyc_o && !rsp_valid_o) break;
      if (++guard > 3000) begin fail_now("drain"); break; end
    end
    @(posedge clock); #1;
  endtask

  // Wishbone slave model
  bus_exp_t cur;
  int       wait_left, stb_len;
  bit       in_cyc, bus_bad;
  initial begin
    wb_ack_i = 1'b0; wb_dat_i = 8'h00; in_cyc = 0;
    forever begin
      @(negedge clock);
      wb_ack_i = 1'b0;
      wb_dat_i = 8'($urandom);
      if (!wb_rst_ni) begin in_cyc = 0; continue; end
      if (wb_cyc_o !== wb_stb_o) cyc_stb_bad++;
      if (wb_stb_o) begin
        if (!in_cyc) begin
          in_cyc = 1; stb_rises++; stb_len = 0; bus_bad = 0;
          if (exp_bus.size() == 0) begin
            n_chk++;
            $display("FAIL bus_extra: unexpected stb at %0t", $time);
            cur = '{we: wb_we_o, addr: wb_addr_o, dat: wb_dat_o, sel: wb_sel_o,
                    len: -1, dly: NEVER};
          end else begin
            cur = exp_bus.pop_front();
            chk("bus_fields", {wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o},
                {cur.we, cur.addr, cur.dat, cur.sel});
          end
          wait_left = cur.dly;
        end else if ({wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o} !==
                     {cur.we, cur.addr, cur.dat, cur.sel}) begin
          bus_bad = 1;
        end
        stb_len++;
        if (wait_left == 0) begin
          wb_ack_i = 1'b1;
          if (wb_we_o) slave_regs[wb_addr_o] = wb_dat_o;
          else wb_dat_i = slave_regs[wb_addr_o];
        end else begin
          wait_left--;
        end
      end else begin
        if (in_cyc) begin
          in_cyc = 0;
          chk("stb_len", stb_len, cur.len);
          chk("bus_stable", 32'(bus_bad), 0);
        end
        if (late_ack > 0) begin wb_ack_i = 1'b1; late_ack--; end
      end
    end
  end

  // Response monitor
  rsp_exp_t e;
  bit       hold_chk = 0;
  logic [8:0] held;
  initial begin
    forever begin
      @(negedge clock);
      if (!wb_rst_ni) begin hold_chk = 0; continue; end
      if (hold_chk) chk("rsp_hold", {rsp_valid_o, rsp_err_o, rsp_data_o}, {1'b1, held});
      hold_chk = 0;
      if (rsp_valid_o) begin
        if (rsp_ready_i) begin
          n_rsp++;
          if (exp_rsp.size() == 0) begin
            n_chk++;
            $display("FAIL rsp_extra: unexpected response data %0h err %0b", rsp_data_o, rsp_err_o);
          end else begin
            e = exp_rsp.pop_front();
            chk("rsp_data", rsp_data_o, e.data);
            chk("rsp_err", rsp_err_o, e.err);
          end
        end else begin
          hold_chk = 1;
          held = {rsp_err_o, rsp_data_o};
        end
      end
    end
  end

  // Response-ready driver
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (rsp_mode)
        0:       rsp_ready_i = 1'b1;
        1:       rsp_ready_i = ($urandom_range(0, 3) != 0);
        default: rsp_ready_i = 1'b0;
      endcase
    end
  end

  int rs, nr, guard, r;
  initial begin
    cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0; cmd_data_i = 0;
    for (int i = 0; i < 32; i++) begin
      slave_regs[i] = 8'($urandom);
      ref_regs[i]   = slave_regs[i];
    end
    slave_regs[LSR] = 8'h60; ref_regs[LSR] = 8'h60;
    wb_rst_ni = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_outputs", {rsp_valid_o, rsp_data_o, rsp_err_o, wb_addr_o, wb_sel_o,
                          wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o}, 0);
    chk("reset_cmd_ready", cmd_ready_o, 1);
    @(posedge clock); #1;
    wb_rst_ni = 1'b1;
    @(posedge clock); #1;

    // Directed: write LCR (ack on 2nd stb cycle), read LSR
    push_cmd(1'b1, LCR, 8'h83, 1);
    push_cmd(1'b0, LSR, 8'h00, 0);
    wait_drain();

    // Timeout, then a stray ack that must be ignored
    push_cmd(1'b0, IER, 8'h00, NEVER);
    wait_drain();
    rs = stb_rises; nr = n_rsp;
    late_ack = 3;
    repeat (6) @(posedge clock); #1;
    chk("late_ack_no_stb", stb_rises, rs);
    chk("late_ack_no_rsp", n_rsp, nr);
    chk("late_ack_idle", {rsp_valid_o, wb_cyc_o}, 0);

    // Boundary: ack exactly on the terminal count, and one cycle too late
    push_cmd(1'b0, LSR, 8'h00, TMO - 1);
    push_cmd(1'b1, IIR_FCR, 8'h5a, TMO - 1);
    push_cmd(1'b1, RBR_THR, 8'ha5, TMO);
    wait_drain();

    // Back-to-back: first command holds the bus while the FIFO fills
    nr = n_rsp;
    push_cmd(1'b1, LCR, 8'h03, 10);
    for (int i = 0; i < 4; i++)
      push_cmd(i[0], 5'(i + 8), 8'(i * 17), i);
    @(negedge clock);
    chk("fifo_full", cmd_ready_o, 0);
    @(posedge clock); #1;
    wait_drain();
    chk("b2b_rsp_count", n_rsp - nr, 5);

    // Randomized traffic with random response backpressure
    rsp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      push_cmd(1'($urandom), 5'($urandom), 8'($urandom),
               (r < 7) ? r % 4 : (r == 7) ? TMO - 1 : (r == 8) ? TMO : NEVER);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clock);
      #0;
    end
    wait_drain();
    rsp_mode = 0;
    @(posedge clock); #1;

    // Backpressure, then reset in the middle of the next bus cycle
    rsp_mode = 2;
    @(posedge clock); #1;
    push_cmd(1'b0, LSR, 8'h00, 2);
    push_cmd(1'b0, LCR, 8'h00, NEVER);
    guard = 0;
    while (!rsp_valid_o && guard < 50) begin @(posedge clock); #1; guard++; end
    if (!rsp_valid_o) fail_now("bp_rsp_valid");
    rs = stb_rises;
    repeat (10) @(posedge clock);
    #1;
    chk("bp_no_stb", {stb_rises, wb_stb_o}, {rs, 1'b0});
    rsp_mode = 0;
    guard = 0;
    while (!wb_stb_o && guard < 20) begin @(posedge clock); #1; guard++; end
    if (!wb_stb_o) fail_now("bp_next_stb");
    repeat (3) @(posedge clock);
    #1;
    wb_rst_ni = 1'b0;
    #1;
    chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    exp_bus.delete();
    exp_rsp.delete();
    repeat (3) @(posedge clock);
    #1;
    wb_rst_ni = 1'b1;
    @(posedge clock); #1;

    // Traffic after reset
    nr = n_rsp;
    push_cmd(1'b1, IER, 8'h0f, 0);
    push_cmd(1'b0, IER, 8'h00, 3);
    wait_drain();
    chk("post_rst_rsp_count", n_rsp - nr, 2);
    chk("cyc_eq_stb", cyc_stb_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
